da_fir_ctrl: RTL and testbench
==============================

# da_fir_ctrl

Sequencing controller for the 5-tap distributed-arithmetic (DA) FIR datapath with coefficients 1, 3, 5, 7, 9. The block accepts one signed parallel sample at a time and keeps the 5-sample delay line. It feeds the external registered DA case table one bit-slice per cycle, LSB first, and shift-accumulates the returned partial sums into the filter output. It sits between the sample source and the DA table.

## Interface
- `W`, 8, sample width in bits, two's complement, W >= 2
- `LUT_LAT`, 3, clock edges from `table_in` sampled by the table to the matching `table_out`, LUT_LAT >= 1
- `YW`, W+6, output/accumulator width, signed
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `x_in`  in  W  input sample, signed
- `x_valid`  in  1  sample offered
- `x_ready`  out  1  block can accept; `x_valid && x_ready` at an edge = accept
- `table_in`  out  5  DA table address; bit k = current bit of tap k (coefficient 2k+1)
- `table_out`  in  5  DA table result, unsigned 0..25
- `y_out`  out  YW  filter result, signed
- `y_valid`  out  1  one-cycle pulse, `y_out` is new

## Operation
- Delay line `d0..d4`: `d0` is the newest sample (coefficient 1), `d4` the oldest (coefficient 9).
- On accept: d4<=d3 … d1<=d0, d0<=x_in. Copy all five into bit shift registers, clear the accumulator, go to RUN.
- FSM states and transitions:
  - IDLE: `x_ready`=1. Accept -> RUN.
  - RUN: W issue cycles. Bit j (j=0..W-1) of every tap is driven on `table_in` in issue cycle j. After the last issue -> DRAIN.
  - DRAIN: wait for the outstanding returns. After the last return is accumulated -> IDLE, with a `y_valid` pulse.
- Return tracking:
  - A LUT_LAT-deep valid/index pipe tags each issue.
  - Each tagged return is accumulated: acc += table_out << j for j < W-1, acc -= table_out << (W-1) for j = W-1 (sign slice).
  - All arithmetic is sign-extended to YW bits. No overflow is possible at the defaults (|y| <= 25·2^(W-1) = 3200).
- `table_in` = 0 whenever no issue is in progress.
- `x_ready` is combinational from state: high only in IDLE. Samples offered in other states are held off, never dropped.
- `y_out` holds its value until the next result.
- Reset (any time, including mid-RUN/DRAIN):
  - state IDLE, delay line and shift registers 0, acc 0, pipes cleared
  - `table_in`=0, `y_out`=0, `y_valid`=0, `x_ready`=1
  - an aborted computation never produces `y_valid`.

## Timing
- Accept at edge 0. The slice for bit j is on `table_in` after edge j+1.
- The table samples that slice at edge j+2. Its return is accumulated at edge j+LUT_LAT+2.
- The final accumulate, the `y_out` update, and `y_valid`=1 all take effect at edge W+LUT_LAT+1 (edge 12 at defaults). The state is IDLE in the same cycle.
- The earliest next accept is edge W+LUT_LAT+2, giving a sample period of W+LUT_LAT+2 cycles (13 at defaults).
- `x_valid` held high continuously gives back-to-back operation at exactly that period.

## Configuration
- `DA_CTRL_OUTREG_EN`:
  - defined: adds one extra register stage on `y_out`/`y_valid`, so the result appears at edge W+LUT_LAT+2. `x_ready` timing and throughput are unchanged.
  - undefined: timing exactly as stated above.

## Test plan
Bench uses W=8 and LUT_LAT=3, with a behavioral table model of coefficients 1, 3, 5, 7, 9 and 3-edge latency.
- Reset asserted then released -> `y_out`=0, `y_valid`=0, `table_in`=0, `x_ready`=1.
- Impulse: samples 1,0,0,0,0 -> successive `y_out` = 1, 3, 5, 7, 9. Each `y_valid` is 12 edges after its accept.
- Sign slice: single sample −128 into a cleared line -> `y_out` = −128. Next sample 0 -> `y_out` = −384.
- Extremes: five samples 127 -> final `y_out` = 3175. Then five samples −128 -> final `y_out` = −3200.
- Streaming: `x_valid` held high with incrementing samples -> accepts every 13 cycles, and `x_ready` is low for 12 cycles after each accept. Outputs match a reference convolution.
- Reset pulsed 5 edges after an accept -> no `y_valid` for that sample. The following impulse 1 yields `y_out` = 1, confirming the delay line was cleared.

Source files
------------

// File: rtl/da_fir_ctrl.sv
// Sequencing controller for a 5-tap DA FIR (coefficients 1,3,5,7,9): delay line, LSB-first
// bit-slice issue to an external registered DA table, tagged shift-accumulate of returns.
// Optional: define DA_CTRL_OUTREG_EN to add one output register stage on y_out/y_valid.
module da_fir_ctrl #(
  parameter int W       = 8,
  parameter int LUT_LAT = 3,
  parameter int YW      = W + 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [W-1:0]  x_in,
  input  logic                 x_valid,
  output logic                 x_ready,
  output logic [4:0]           table_in,
  input  logic [4:0]           table_out,
  output logic signed [YW-1:0] y_out,
  output logic                 y_valid
);

  localparam int IW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [4:0][W-1:0]         dl_q, dl_d;
  logic [4:0][W-1:0]         sh_q, sh_d;
  logic [IW-1:0]             cnt_q, cnt_d;
  logic [LUT_LAT:0]          tag_vld_q, tag_vld_d;
  logic [LUT_LAT:0][IW-1:0]  tag_idx_q, tag_idx_d;
  logic signed [YW-1:0]      acc_q, acc_d;
  logic signed [YW-1:0]      y_q, y_d;
  logic                      yv_q, yv_d;
  logic [4:0]                tin_q, tin_d;
  logic [YW-1:0]             term;

  always_comb begin
    state_d   = state_q;
    dl_d      = dl_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    y_d       = y_q;
    yv_d      = 1'b0;
    tin_d     = '0;
    // Stage 0 tags the slice driven on table_in; the top stage lines up with table_out.
    tag_vld_d = {tag_vld_q[LUT_LAT-1:0], 1'b0};
    tag_idx_d = {tag_idx_q[LUT_LAT-1:0], {IW{1'b0}}};
    term      = YW'(table_out) << tag_idx_q[LUT_LAT];

    case (state_q)
      IDLE: begin
        if (x_valid) begin
          dl_d    = {dl_q[3:0], x_in};
          sh_d    = {dl_q[3:0], x_in};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned k = 0; k < 5; k++) begin
          tin_d[k] = sh_q[k][0];
          sh_d[k]  = sh_q[k] >> 1;
        end
        tag_vld_d[0] = 1'b1;
        tag_idx_d[0] = cnt_q;
        cnt_d        = cnt_q + IW'(1);
        if (cnt_q == IW'(W - 1)) state_d = DRAIN;
      end
      default: ;
    endcase

    // The MSB slice carries negative weight in two's complement.
    if (tag_vld_q[LUT_LAT]) begin
      if (tag_idx_q[LUT_LAT] == IW'(W - 1)) begin
        acc_d   = acc_q - $signed(term);
        y_d     = acc_d;
        yv_d    = 1'b1;
        state_d = IDLE;
      end else begin
        acc_d = acc_q + $signed(term);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      dl_q      <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
      tag_vld_q <= '0;
      tag_idx_q <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      yv_q      <= 1'b0;
      tin_q     <= '0;
    end else begin
      state_q   <= state_d;
      dl_q      <= dl_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      yv_q      <= yv_d;
      tin_q     <= tin_d;
    end
  end

  assign x_ready  = (state_q == IDLE);
  assign table_in = tin_q;

`ifdef DA_CTRL_OUTREG_EN
  logic signed [YW-1:0] y_r_q;
  logic                 yv_r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_r_q  <= '0;
      yv_r_q <= 1'b0;
    end else begin
      y_r_q  <= y_q;
      yv_r_q <= yv_q;
    end
  end

  assign y_out   = y_r_q;
  assign y_valid = yv_r_q;
`else
  assign y_out   = y_q;
  assign y_valid = yv_q;
`endif

endmodule

// File: tb/tb_da_fir_ctrl.sv
// Directed self-checking bench for da_fir_ctrl with a behavioral 3-edge DA table model.
module tb_da_fir_ctrl;

  localparam int W  = 8;
  localparam int YW = W + 6;

  logic                 clk;
  logic                 reset;
  logic signed [W-1:0]  x_in;
  logic                 x_valid;
  logic                 x_ready;
  logic [4:0]           table_in;
  logic [4:0]           table_out;
  logic signed [YW-1:0] y_out;
  logic                 y_valid;

  int ncmp;
  int nfail;

  da_fir_ctrl #(.W(W), .LUT_LAT(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .x_in     (x_in),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .table_in (table_in),
    .table_out(table_out),
    .y_out    (y_out),
    .y_valid  (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External DA table: sum of (2k+1) over set address bits, 3 edges of latency.
  logic [4:0] t1, t2, t3;
  function automatic logic [4:0] da_sum(input logic [4:0] a);
    int s;
    s = 0;
    for (int k = 0; k < 5; k++) if (a[k]) s += 2 * k + 1;
    return 5'(s);
  endfunction
  always @(posedge clk) begin
    t1 <= da_sum(table_in);
    t2 <= t1;
    t3 <= t2;
  end
  assign table_out = t3;

  task automatic do_reset();
    reset   = 1'b0;
    x_valid = 1'b0;
    x_in    = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_and_check(input logic signed [W-1:0] x, input int exp_y, input string nm);
    int  n;
    bit  seen;
    logic signed [YW-1:0] held;
    n = 0;
    while (!x_ready && n < 40) begin @(posedge clk); #1; n++; end
    ncmp++;
    if (x_ready !== 1'b1) begin
      nfail++;
      $display("FAIL %s ready_wait: x_ready=%b required 1", nm, x_ready);
      return;
    end
    x_in = x; x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    ncmp++;
    if (x_ready !== 1'b0) begin
      nfail++;
      $display("FAIL %s busy_after_accept: x_ready=%b required 0", nm, x_ready);
    end
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (y_valid === 1'b1) seen = 1;
    end
    ncmp++;
    if (!seen || n != 12) begin
      nfail++;
      $display("FAIL %s latency: seen=%0d edges=%0d required 12", nm, seen, n);
    end
    ncmp++;
    if (int'(y_out) != exp_y) begin
      nfail++;
      $display("FAIL %s y_out: got %0d required %0d", nm, y_out, exp_y);
    end
    held = y_out;
    @(posedge clk); #1;
    ncmp++;
    if (y_valid !== 1'b0 || y_out !== held || table_in !== 5'd0) begin
      nfail++;
      $display("FAIL %s pulse_hold: y_valid=%b y_out=%0d table_in=%h required 0/%0d/0",
               nm, y_valid, y_out, table_in, held);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; x_valid = 1'b0; x_in = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    ncmp++;
    if (y_out !== '0 || y_valid !== 1'b0 || table_in !== 5'd0 || x_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_state: y_out=%0d y_valid=%b table_in=%h x_ready=%b required 0/0/0/1",
               y_out, y_valid, table_in, x_ready);
    end
  endtask

  task automatic test_impulse();
    do_reset();
    send_and_check(8'sd1, 1, "impulse0");
    send_and_check(8'sd0, 3, "impulse1");
    send_and_check(8'sd0, 5, "impulse2");
    send_and_check(8'sd0, 7, "impulse3");
    send_and_check(8'sd0, 9, "impulse4");
  endtask

  task automatic test_sign_slice();
    do_reset();
    send_and_check(-8'sd128, -128, "sign0");
    send_and_check(8'sd0, -384, "sign1");
  endtask

  task automatic test_extremes();
    int exp_pos [5] = '{127, 508, 1143, 2032, 3175};
    int exp_neg [5] = '{2920, 2155, 880, -905, -3200};
    do_reset();
    for (int i = 0; i < 5; i++) send_and_check(8'sd127, exp_pos[i], "max");
    for (int i = 0; i < 5; i++) send_and_check(-8'sd128, exp_neg[i], "min");
  endtask

  task automatic test_back_to_back();
    int rd [5];
    int expq [$];
    int accepts, cyc, last_acc, low_cnt, yexp;
    bit rdy;
    do_reset();
    for (int i = 0; i < 5; i++) rd[i] = 0;
    accepts = 0; cyc = 0; last_acc = 0; low_cnt = 0;
    x_in = 8'sd1; x_valid = 1'b1;
    while ((accepts < 6 || expq.size() > 0) && cyc < 200) begin
      rdy = x_ready && x_valid;
      @(posedge clk); #1; cyc++;
      if (y_valid === 1'b1) begin
        yexp = (expq.size() > 0) ? expq.pop_front() : 32'h7fffffff;
        ncmp++;
        if (int'(y_out) != yexp) begin
          nfail++;
          $display("FAIL stream_y: got %0d required %0d", y_out, yexp);
        end
      end
      if (rdy) begin
        if (accepts > 0) begin
          ncmp++;
          if (cyc - last_acc != 13 || low_cnt != 12) begin
            nfail++;
            $display("FAIL stream_period: period=%0d busy=%0d required 13/12",
                     cyc - last_acc, low_cnt);
          end
        end
        for (int i = 4; i > 0; i--) rd[i] = rd[i-1];
        rd[0] = int'(x_in);
        expq.push_back(rd[0] + 3 * rd[1] + 5 * rd[2] + 7 * rd[3] + 9 * rd[4]);
        accepts++; last_acc = cyc; low_cnt = 0;
        x_in = x_in + 8'sd1;
        if (accepts == 6) x_valid = 1'b0;
      end
      if (x_ready === 1'b0) low_cnt++;
    end
    ncmp++;
    if (accepts != 6 || expq.size() != 0) begin
      nfail++;
      $display("FAIL stream_done: accepts=%0d pending=%0d required 6/0", accepts, expq.size());
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    do_reset();
    x_in = 8'sd50; x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    ncmp++;
    if (table_in !== 5'd0 || x_ready !== 1'b1 || y_valid !== 1'b0) begin
      nfail++;
      $display("FAIL abort_reset_state: table_in=%h x_ready=%b y_valid=%b required 0/1/0",
               table_in, x_ready, y_valid);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (y_valid === 1'b1) seen = 1;
    end
    ncmp++;
    if (seen) begin
      nfail++;
      $display("FAIL abort_no_result: y_valid seen=1 required 0");
    end
    send_and_check(8'sd1, 1, "abort_impulse");
  endtask

  initial begin
    ncmp = 0; nfail = 0;
    reset = 1'b0; x_valid = 1'b0; x_in = '0;
    test_reset();
    test_impulse();
    test_sign_slice();
    test_extremes();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
